// File: rtl/shift_add_multiplier.sv
// Sequential 8x8 unsigned multiplier. A single 8-bit ripple-carry adder is
// reused over eight shift-add iterations to build a 16-bit product.
//
// Handshake: start is accepted on a rising clock edge only when ready=1.
// a and b are captured on that same edge. Once a request is accepted, start
// is ignored until ready returns. done pulses for one cycle when the product
// updates. product then holds until the next completion.

module adder_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       carry
);

    logic c;

    // Ripple the carry through the bits, from the LSB to the MSB.
    always_comb begin
        c   = cin;
        sum = 8'h00;
        for (int i = 0; i < 8; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        carry = c;
    end

endmodule

module shift_add_multiplier (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic [15:0] product
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [7:0]  m_reg;    // multiplicand
    logic [7:0]  q_reg;    // multiplier, shifting out as low product bits shift in
    logic [7:0]  a_reg;    // accumulator / high product
    logic [3:0]  cnt;      // iteration index 0..7
    logic [7:0]  addend;
    logic [7:0]  sum;
    logic        carry;
    logic [7:0]  a_shift;
    logic [7:0]  q_shift;

    // Add the multiplicand only when the current multiplier LSB is set.
    assign addend = q_reg[0] ? m_reg : 8'h00;

    adder_8bit u_adder (
        .a     (a_reg),
        .b     (addend),
        .cin   (1'b0),
        .sum   (sum),
        .carry (carry)
    );

    // {carry, sum, Q} shifted right by one. The carry becomes the new A MSB,
    // so the ninth bit of each partial sum is never lost. The carry register
    // would always read back 0 after this shift, so it is not stored.
    assign a_shift = {carry, sum[7:1]};
    assign q_shift = {sum[0], q_reg[7:1]};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. The iteration count is fixed at 8 and there is no early exit.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = BUSY;
            BUSY:    if (cnt == 4'd7) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs are decoded from state only, so nothing depends on start, a or b.
    always_comb begin
        ready = (state == IDLE);
        busy  = (state == BUSY);
        done  = (state == DONE);
    end

    // Datapath: capture the operands, step once per BUSY cycle, and load product on the last step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_reg   <= 8'h00;
            q_reg   <= 8'h00;
            a_reg   <= 8'h00;
            cnt     <= 4'd0;
            product <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m_reg <= a;
                        q_reg <= b;
                        a_reg <= 8'h00;
                        cnt   <= 4'd0;
                    end
                end
                BUSY: begin
                    a_reg <= a_shift;
                    q_reg <= q_shift;
                    cnt   <= cnt + 4'd1;
                    if (cnt == 4'd7) begin
                        product <= {a_shift, q_shift};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier. Expected products come from
// the bench's own multiply and are queued when a request is driven. Each
// done pulse pops and compares one expected product.

module tb_shift_add_multiplier;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        ready;
    logic        busy;
    logic        done;
    logic [15:0] product;

    logic [15:0] exp_q[$];
    int          n_checks;
    int          n_errors;
    int          done_count;

    shift_add_multiplier dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // scoreboard: every done pulse consumes one expected product
    always @(negedge clk) begin
        if (rst_n && done) begin
            done_count++;
            if (exp_q.size() == 0) begin
                check_val("spurious_done", 16'd1, 16'd0);
            end else begin
                check_val("product", product, exp_q.pop_front());
            end
        end
    end

    // Wait up to a cycle budget for done. Count the busy cycles seen and check that product holds meanwhile.
    task automatic wait_done(input logic [15:0] held, output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cnt++;
            check_val("product_hold", product, held);
            @(negedge clk);
            lat++;
        end
        if (!done) check_val("done_timeout", 16'd0, 16'd1);
    endtask

    // driver: one request with full timing checks
    task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic [15:0] prev);
        int lat, bc;
        @(negedge clk);
        check_val("ready_before", {15'd0, ready}, 16'd1);
        start = 1'b1;
        a     = x;
        b     = y;
        exp_q.push_back(16'(x) * 16'(y));
        @(negedge clk);
        start = 1'b0;
        a     = $urandom_range(0, 255);
        b     = $urandom_range(0, 255);
        wait_done(prev, lat, bc);
        check_val("latency", 16'(lat), 16'd8);
        check_val("busy_cycles", 16'(bc), 16'd8);
        check_val("ready_in_done", {15'd0, ready}, 16'd0);
        @(negedge clk);
        check_val("done_one_cycle", {15'd0, done}, 16'd0);
        check_val("ready_after", {15'd0, ready}, 16'd1);
    endtask

    initial begin
        int          lat, bc, dc0;
        logic [15:0] prev;
        logic [7:0]  rx, ry;
        n_checks   = 0;
        n_errors   = 0;
        done_count = 0;
        start      = 1'b0;
        a          = 8'h00;
        b          = 8'h00;
        rst_n      = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_ready", {15'd0, ready}, 16'd1);
        check_val("rst_busy", {15'd0, busy}, 16'd0);
        check_val("rst_done", {15'd0, done}, 16'd0);
        check_val("rst_product", product, 16'h0000);
        rst_n = 1'b1;

        // directed cases
        run_op(8'h0D, 8'h0B, 16'h0000);
        check_val("p_13x11", product, 16'h008F);
        run_op(8'hFF, 8'hFF, 16'h008F);
        check_val("p_ffxff", product, 16'hFE01);
        run_op(8'hA5, 8'h00, 16'hFE01);
        run_op(8'h00, 8'hA5, 16'h0000);
        prev = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            rx = $urandom_range(0, 255);
            ry = $urandom_range(0, 255);
            run_op(rx, ry, prev);
            prev = 16'(rx) * 16'(ry);
        end

        // start during BUSY is ignored
        dc0 = done_count;
        @(negedge clk);
        start = 1'b1; a = 8'd3; b = 8'd5;
        exp_q.push_back(16'h000F);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; a = 8'hFF; b = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        wait_done(prev, lat, bc);
        check_val("ign_latency", 16'(lat + 4), 16'd8);
        repeat (15) @(negedge clk);
        check_val("ign_one_done", 16'(done_count - dc0), 16'd1);
        check_val("ign_product", product, 16'h000F);

        // start held continuously: one accept every 10 cycles
        @(negedge clk);
        start = 1'b1; a = 8'd2; b = 8'd7;
        for (int i = 0; i < 3; i++) exp_q.push_back(16'h000E);
        @(negedge clk);
        wait_done(16'h000F, lat, bc);
        check_val("b2b_first_lat", 16'(lat), 16'd8);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            wait_done(16'h000E, lat, bc);
            check_val("b2b_interval", 16'(lat + 1), 16'd10);
        end
        start = 1'b0;
        repeat (12) @(negedge clk);

        // reset in the middle of an operation
        @(negedge clk);
        start = 1'b1; a = 8'h80; b = 8'h80;
        exp_q.push_back(16'h4000);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        check_val("mid_rst_product", product, 16'h0000);
        check_val("mid_rst_done", {15'd0, done}, 16'd0);
        check_val("mid_rst_busy", {15'd0, busy}, 16'd0);
        check_val("mid_rst_ready", {15'd0, ready}, 16'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_val("post_rst_product", product, 16'h0000);
        run_op(8'h80, 8'h80, 16'h0000);
        check_val("p_80x80", product, 16'h4000);

        repeat (3) @(negedge clk);
        check_val("queue_empty", 16'(exp_q.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
